// File: rtl/rst_seq_pkg.sv
// ============================================================================
// Module   : rst_seq_pkg
// Brief    : Shared types and sizing helpers for the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_t;

    // Width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_n.sv
// ============================================================================
// Module   : sync_n
// Brief    : Multi-flop synchronizer for a single asynchronous input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_n #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync_q;
    logic [STAGES-1:0] w_sync_d;

    always_comb begin
        w_sync_d = {r_sync_q[STAGES-2:0], i_async};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q <= {STAGES{RESET_VAL}};
        end else begin
            r_sync_q <= w_sync_d;
        end
    end

    assign o_sync = r_sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_seq.sv
// ============================================================================
// Module   : rst_seq
// Brief    : Reset sequencer - synchronizes/merges reset requests, enforces a
//            quiet hold time, then releases active-low resets in order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ext_rst_req_n,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               seq_done
);

    localparam int c_cnt_w = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int c_idx_w = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);

    initial begin
        if (SYNC_STAGES < 2) $fatal(1, "rst_seq: SYNC_STAGES must be >= 2");
        if (NUM_OUT < 1)     $fatal(1, "rst_seq: NUM_OUT must be >= 1");
        if (HOLD_CYCLES < 1) $fatal(1, "rst_seq: HOLD_CYCLES must be >= 1");
        if (GAP_CYCLES < 1)  $fatal(1, "rst_seq: GAP_CYCLES must be >= 1");
    end

    logic w_ext_sync_n;
    logic w_req;

    rst_seq_state_t     r_state_q,   w_state_d;
    logic [c_cnt_w-1:0] r_cnt_q,     w_cnt_d;
    logic [c_idx_w-1:0] r_idx_q,     w_idx_d;
    logic [NUM_OUT-1:0] r_rst_out_q, w_rst_out_d;
    logic               r_done_q,    w_done_d;

    // Synchronizer resets to 0 so a reset looks like an asserted pin request.
    sync_n #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_ext_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ext_rst_req_n),
        .o_sync  (w_ext_sync_n)
    );

    assign w_req = ~w_ext_sync_n | sw_rst_req;

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_idx_d     = r_idx_q;
        w_rst_out_d = r_rst_out_q;
        w_done_d    = r_done_q;

        case (r_state_q)
            HOLD: begin
                w_rst_out_d = '0;
                w_done_d    = 1'b0;
                if (w_req) begin
                    w_cnt_d = '0;
                end else if (r_cnt_q == c_hold_last) begin
                    w_rst_out_d[0] = 1'b1;
                    w_cnt_d        = '0;
                    w_idx_d        = '0;
                    if (NUM_OUT == 1) begin
                        w_state_d = RUN;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = RELEASE;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_cnt_one;
                end
            end

            RELEASE: begin
                if (w_req) begin
                    w_state_d   = HOLD;
                    w_rst_out_d = '0;
                    w_done_d    = 1'b0;
                    w_cnt_d     = '0;
                end else if (r_cnt_q == c_gap_last) begin
                    // Only the next channel is set, keeping a thermometer code.
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (i == int'(r_idx_q) + 1) w_rst_out_d[i] = 1'b1;
                    end
                    w_idx_d = r_idx_q + c_idx_one;
                    w_cnt_d = '0;
                    if (int'(r_idx_q) + 1 == NUM_OUT - 1) begin
                        w_state_d = RUN;
                        w_done_d  = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_cnt_one;
                end
            end

            RUN: begin
                if (w_req) begin
                    w_state_d   = HOLD;
                    w_rst_out_d = '0;
                    w_done_d    = 1'b0;
                    w_cnt_d     = '0;
                end
            end

            default: begin
                w_state_d   = HOLD;
                w_rst_out_d = '0;
                w_done_d    = 1'b0;
                w_cnt_d     = '0;
                w_idx_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= HOLD;
            r_cnt_q     <= '0;
            r_idx_q     <= '0;
            r_rst_out_q <= '0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_idx_q     <= w_idx_d;
            r_rst_out_q <= w_rst_out_d;
            r_done_q    <= w_done_d;
        end
    end

    assign rst_out_n = r_rst_out_q;
    assign seq_done  = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
// Module   : tb_rst_seq
// Brief    : Directed-vector bench for rst_seq (default and minimal configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_n;
    logic       sw_req;
    logic [3:0] out_n;
    logic       done;
    logic [0:0] s_out_n;
    logic       s_done;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    rst_seq #(
        .SYNC_STAGES (2),
        .NUM_OUT     (4),
        .HOLD_CYCLES (16),
        .GAP_CYCLES  (8)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .ext_rst_req_n (ext_n),
        .sw_rst_req    (sw_req),
        .rst_out_n     (out_n),
        .seq_done      (done)
    );

    rst_seq #(
        .SYNC_STAGES (2),
        .NUM_OUT     (1),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (1)
    ) u_dut_min (
        .clk           (clk),
        .rst           (rst),
        .ext_rst_req_n (ext_n),
        .sw_rst_req    (sw_req),
        .rst_out_n     (s_out_n),
        .seq_done      (s_done)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic chk_main(input string tag, input logic [3:0] exp_out, input logic exp_done);
        check_vec({tag, "_out"}, {28'd0, out_n}, {28'd0, exp_out});
        check_vec({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        ext_n  = 1'b1;
        sw_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_main("reset", 4'b0000, 1'b0);
        check_vec("min_reset_out", {31'd0, s_out_n}, 32'd0);
        rst    = 1'b0;
        edge_n = 0;

        // Power-up release schedule
        run_to(2);
        check_vec("min_e2_out", {31'd0, s_out_n}, 32'd0);
        check_vec("min_e2_done", {31'd0, s_done}, 32'd0);
        run_to(3);
        check_vec("min_e3_out", {31'd0, s_out_n}, 32'd1);
        check_vec("min_e3_done", {31'd0, s_done}, 32'd1);
        run_to(17);  chk_main("pu17", 4'b0000, 1'b0);
        run_to(18);  chk_main("pu18", 4'b0001, 1'b0);
        run_to(25);  chk_main("pu25", 4'b0001, 1'b0);
        run_to(26);  chk_main("pu26", 4'b0011, 1'b0);
        run_to(34);  chk_main("pu34", 4'b0111, 1'b0);
        run_to(41);  chk_main("pu41", 4'b0111, 1'b0);
        run_to(42);  chk_main("pu42", 4'b1111, 1'b1);

        // Software reset pulse sampled at edge 100
        run_to(99);
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        chk_main("sw100", 4'b0000, 1'b0);
        run_to(115); chk_main("sw115", 4'b0000, 1'b0);
        run_to(116); chk_main("sw116", 4'b0001, 1'b0);
        run_to(140); chk_main("sw140", 4'b1111, 1'b1);

        // One-cycle pin glitch while two channels are released
        run_to(149);
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        run_to(166); chk_main("gl166", 4'b0001, 1'b0);
        run_to(174); chk_main("gl174", 4'b0011, 1'b0);
        run_to(176);
        ext_n = 1'b0;
        tick();
        ext_n = 1'b1;
        tick();      chk_main("gl178", 4'b0011, 1'b0);
        tick();      chk_main("gl179", 4'b0000, 1'b0);
        run_to(194); chk_main("gl194", 4'b0000, 1'b0);
        run_to(195); chk_main("gl195", 4'b0001, 1'b0);
        run_to(203); chk_main("gl203", 4'b0011, 1'b0);
        run_to(219); chk_main("gl219", 4'b1111, 1'b1);

        // Bouncing pin: low for one cycle every ten cycles, five times
        run_to(230);
        for (int e = 231; e <= 288; e++) begin
            ext_n = !(((e - 231) % 10 == 0) && (e <= 271));
            tick();
            if (e >= 233) chk_main("bounce", 4'b0000, 1'b0);
        end
        ext_n = 1'b1;
        run_to(289); chk_main("bounce289", 4'b0001, 1'b0);
        run_to(313); chk_main("bounce313", 4'b1111, 1'b1);

        // rst together with a software request while in RUN
        run_to(319);
        rst    = 1'b1;
        sw_req = 1'b1;
        tick();
        chk_main("rst320", 4'b0000, 1'b0);
        check_vec("min_rst320_out", {31'd0, s_out_n}, 32'd0);
        rst    = 1'b0;
        sw_req = 1'b0;
        run_to(337); chk_main("rst337", 4'b0000, 1'b0);
        run_to(338); chk_main("rst338", 4'b0001, 1'b0);
        run_to(362); chk_main("rst362", 4'b1111, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer for the equalizer top level. Synchronizes an asynchronous active-low external reset request (push-button) through a configurable synchronizer chain and merges it with a synchronous software reset request. It enforces a minimum quiet hold time, then releases NUM_OUT active-low reset outputs one at a time, GAP_CYCLES apart: codec/I2S first, then SPI, filters and output stage. `seq_done` flags that every downstream block is out of reset.

## Interface
- SYNC_STAGES, 2: flops in the external-request synchronizer; must be ≥2.
- NUM_OUT, 4: number of sequenced reset outputs; must be ≥1.
- HOLD_CYCLES, 16: consecutive request-free cycles required before release starts; must be ≥1.
- GAP_CYCLES, 8: cycles between successive channel releases; must be ≥1.
- clk  input  1  system clock; all flops update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ext_rst_req_n  input  1  asynchronous active-low external reset request.
- sw_rst_req  input  1  synchronous active-high software reset request (level or pulse).
- rst_out_n  output  NUM_OUT  active-low reset outputs; bit 0 releases first.
- seq_done  output  1  high when every rst_out_n bit is high.

## Operation
- Synchronizer: ext_rst_req_n passes through SYNC_STAGES flops. Every flop resets to 0 (request asserted). The last stage gives ext_sync_n.
- Request: req = !ext_sync_n | sw_rst_req.
- One shared counter, cnt, serves both hold and gap timing. Width = $clog2(max(HOLD_CYCLES, GAP_CYCLES)).
- Channel index, idx, has width $clog2(NUM_OUT), minimum 1.
- Reset (rst=1): state=HOLD, cnt=0, idx=0, rst_out_n=all 0, seq_done=0, synchronizer=all 0.
- HOLD: rst_out_n all 0 and seq_done 0.
  - If req: cnt←0.
  - Else if cnt==HOLD_CYCLES-1: rst_out_n[0]←1, cnt←0, idx←0. Go to RUN with seq_done←1 if NUM_OUT==1; otherwise go to RELEASE.
  - Else: cnt←cnt+1.
- RELEASE:
  - If req: go to HOLD; rst_out_n←0, seq_done←0, cnt←0.
  - Else if cnt==GAP_CYCLES-1: rst_out_n[idx+1]←1, idx←idx+1, cnt←0. If idx+1==NUM_OUT-1, go to RUN with seq_done←1.
  - Else: cnt←cnt+1.
- RUN: outputs hold.
  - If req: go to HOLD; rst_out_n←0, seq_done←0, cnt←0.
- Invariant: rst_out_n is always a thermometer code (low bits high, contiguous). Outputs are never released out of order.
- Request assertion drops every output on the same edge, regardless of state, cnt or idx. There is no staggered assertion.
- A single-cycle req restarts the full HOLD count (glitch/debounce rule).
- rst has priority over req.

## Timing
- Edge 1 is the first rising edge sampling rst=0, with ext_rst_req_n high and sw_rst_req low.
- ext_sync_n goes high at edge SYNC_STAGES.
- rst_out_n[0] rises at edge SYNC_STAGES+HOLD_CYCLES (defaults: 18).
- rst_out_n[i] rises at edge SYNC_STAGES+HOLD_CYCLES+i·GAP_CYCLES.
- seq_done rises on the same edge as rst_out_n[NUM_OUT-1] (defaults: 42).
- For sw_rst_req sampled high at edge E with no further request: all outputs low after edge E, and rst_out_n[0] rises at edge E+HOLD_CYCLES.
- External request: outputs go low SYNC_STAGES edges after the pin falls (±1 cycle of synchronizer uncertainty).
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package rst_seq_pkg holds:
  - typedef enum logic [1:0] {HOLD, RELEASE, RUN} rst_seq_state_t
  - helper function for the counter width (max/clog2).
- Sub-module sync_n (parametrised STAGES, RESET_VAL) implements the synchronizer chain. It is reused elsewhere for other asynchronous inputs.
- Parameter checks run in an initial block; $fatal on violation.

## Test plan
- Power-up, defaults: rst high 5 cycles then low, pin high → rst_out_n = 0001 at edge 18, 0011 at 26, 0111 at 34, 1111 at 42; seq_done rises at edge 42 only.
- sw_rst_req one-cycle pulse at edge 100 in RUN → rst_out_n=0000 and seq_done=0 after edge 100; 0001 at edge 116; 1111 at edge 140.
- Pin low for 1 cycle mid-RELEASE (rst_out_n=0011) → all outputs 0 two edges later; full HOLD re-count, then ordered re-release.
- Pin bouncing (low 1 cycle every 10 cycles) → rst_out_n stays 0000 and seq_done stays 0 throughout; release begins HOLD_CYCLES after the last bounce.
- NUM_OUT=1, HOLD_CYCLES=1, GAP_CYCLES=1 → rst_out_n[0] and seq_done rise together at edge 3.
- rst asserted while in RUN, sw_rst_req also high → everything back at reset values next edge; the synchronizer refills before counting restarts.
